// File: rtl/signed_or_unsigned_div.sv
// signed_or_unsigned_div
// ----------------------
// Multi-cycle restoring divider producing an n-bit quotient and remainder,
// either unsigned or two's-complement, selected per operation.
// The operands are converted to magnitudes when they are accepted. The
// restoring loop then runs one quotient bit per clock, MSB first. The
// sign of the quotient and remainder is fixed on the final iteration edge.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands/mode valid            (input handshake)
//   in_ready     divider idle, can accept       (input handshake)
//   a, b         dividend, divisor (n bits)
//   signed_div   1 = two's-complement, 0 = unsigned; sampled with a/b
//   out_valid    result valid                   (output handshake)
//   out_ready    consumer accepts the result    (output handshake)
//   quot, rem    quotient, remainder (n bits); hold until the next result
//   div_by_zero  result came from b == 0; valid with out_valid
//
// Division by zero runs through the same states with the same latency.
// Its result is quot = all ones and rem = the original dividend bits.

module signed_or_unsigned_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] quot,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);

  localparam int              CNT_W     = $clog2(n);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(n - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [n-1:0]     ALL_ONES  = {n{1'b1}};
  localparam logic [n-1:0]     ZERO_N    = {n{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Two's-complement negation.
  function automatic logic [n-1:0] neg2(input logic [n-1:0] x);
    return (~x) + {{(n-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; raw bits in unsigned mode.
  function automatic logic [n-1:0] magnitude(input logic [n-1:0] x, input logic is_signed);
    return (is_signed && x[n-1]) ? neg2(x) : x;
  endfunction

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [n-1:0]     prem_q,     prem_d;      // partial remainder (below divisor magnitude)
  logic [n-1:0]     dvd_q,      dvd_d;       // dividend bits out at the top, quotient bits in at the bottom
  logic [n-1:0]     dvs_q,      dvs_d;       // divisor magnitude
  logic [n-1:0]     a_raw_q,    a_raw_d;     // original dividend bits, for the divide-by-zero result
  logic             mode_q,     mode_d;
  logic             a_neg_q,    a_neg_d;
  logic             b_neg_q,    b_neg_d;
  logic [n-1:0]     quot_q,     quot_d;
  logic [n-1:0]     rem_q,      rem_d;
  logic             dbz_q,      dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // One restoring step. The shifted value is the n+1 bit partial
  // remainder. Once a subtraction fits, the difference is below the
  // divisor, so it can be stored in n bits.
  logic [n:0]   prem_shift_s;
  logic         fits_s;
  logic [n-1:0] prem_next_s;
  logic [n-1:0] quot_mag_s;
  logic [n-1:0] quot_res_s;
  logic [n-1:0] rem_res_s;

  // Datapath for one iteration plus the sign correction of the final result.
  always_comb begin
    prem_shift_s = {prem_q, dvd_q[n-1]};
    fits_s       = (prem_shift_s >= {1'b0, dvs_q});
    if (fits_s) begin
      prem_next_s = prem_shift_s[n-1:0] - dvs_q;
    end else begin
      prem_next_s = prem_shift_s[n-1:0];
    end
    quot_mag_s = {dvd_q[n-2:0], fits_s};
    if (mode_q && (a_neg_q ^ b_neg_q)) begin
      quot_res_s = neg2(quot_mag_s);
    end else begin
      quot_res_s = quot_mag_s;
    end
    if (mode_q && a_neg_q) begin
      rem_res_s = neg2(prem_next_s);
    end else begin
      rem_res_s = prem_next_s;
    end
  end

  // Next-state and register-input logic for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    a_raw_d     = a_raw_q;
    mode_d      = mode_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          mode_d     = signed_div;
          a_neg_d    = a[n-1];
          b_neg_d    = b[n-1];
          a_raw_d    = a;
          dvd_d      = magnitude(a, signed_div);
          dvs_d      = magnitude(b, signed_div);
          prem_d     = ZERO_N;
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          state_d    = S_CALC;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_CALC: begin
        prem_d = prem_next_s;
        dvd_d  = quot_mag_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ITER) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          if (dvs_q == ZERO_N) begin
            quot_d = ALL_ONES;
            rem_d  = a_raw_q;
            dbz_d  = 1'b1;
          end else begin
            quot_d = quot_res_s;
            rem_d  = rem_res_s;
            dbz_d  = 1'b0;
          end
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        // in_ready only rises after this edge, so no accept can coincide.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      prem_q      <= ZERO_N;
      dvd_q       <= ZERO_N;
      dvs_q       <= ZERO_N;
      a_raw_q     <= ZERO_N;
      mode_q      <= 1'b0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      quot_q      <= ZERO_N;
      rem_q       <= ZERO_N;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      a_raw_q     <= a_raw_d;
      mode_q      <= mode_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Directed and randomised self-checking bench for signed_or_unsigned_div (n = 8).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_signed_or_unsigned_div;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       signed_div;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quot;
  logic [7:0] rem;
  logic       div_by_zero;

  int checks_cnt = 0;
  int errors_cnt = 0;

  signed_or_unsigned_div #(.n(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_div  (signed_div),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {div_by_zero, quot, rem} from SystemVerilog / and % in 32-bit ints.
  function automatic logic [16:0] ref_div(input logic [7:0] x, input logic [7:0] y, input logic s);
    int xi;
    int yi;
    int qi;
    int ri;
    if (y == 8'd0) return {1'b1, 8'hFF, x};
    if (s) begin
      xi = {{24{x[7]}}, x};
      yi = {{24{y[7]}}, y};
    end else begin
      xi = {24'd0, x};
      yi = {24'd0, y};
    end
    qi = xi / yi;
    ri = xi % yi;
    return {1'b0, qi[7:0], ri[7:0]};
  endfunction

  // Run one operation. hold = cycles of out_ready low after out_valid.
  // lat counts rising edges from the accept edge (as edge 1) to the edge
  // that raises out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input int hold, output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output int lat);
    int w;
    @(negedge clk);
    out_ready  = (hold == 0);
    a          = ta;
    b          = tb_v;
    signed_div = ts;
    in_valid   = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid   = 1'b0;
    a          = ~ta;
    b          = 8'h5A;
    signed_div = ~ts;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check_eq("result_timeout", 32'd0, 32'd1);
    q  = quot;
    r  = rem;
    dz = div_by_zero;
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 2);
      a        = 8'h11;
      b        = 8'h01;
      @(negedge clk);
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_ready", {31'd0, in_ready}, 32'd0);
      check_eq("hold_quot", {24'd0, quot}, {24'd0, q});
      check_eq("hold_rem", {24'd0, rem}, {24'd0, r});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vs;
    logic [7:0] eq;
    logic [7:0] er;
    logic       ez;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
    logic [16:0] exp_v;
    int          bad_valid;

    vecs[0] = '{8'd200, 8'd7,  1'b0, 8'd28,  8'd4,  1'b0};
    vecs[1] = '{8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0};
    vecs[2] = '{8'hF9,  8'h02, 1'b0, 8'h7C,  8'h01, 1'b0};
    vecs[3] = '{8'h07,  8'hFE, 1'b1, 8'hFD,  8'h01, 1'b0};
    vecs[4] = '{8'h2A,  8'h00, 1'b1, 8'hFF,  8'h2A, 1'b1};
    vecs[5] = '{8'h2A,  8'h00, 1'b0, 8'hFF,  8'h2A, 1'b1};
    vecs[6] = '{8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0};
    vecs[7] = '{8'hF9,  8'hFE, 1'b1, 8'h03,  8'hFF, 1'b0};
    vecs[8] = '{8'hFF,  8'hFF, 1'b0, 8'h01,  8'h00, 1'b0};
    vecs[9] = '{8'h05,  8'h09, 1'b0, 8'h00,  8'h05, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = 8'd0;
    b          = 8'd0;
    signed_div = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_quot", {24'd0, quot}, 32'd0);
    check_eq("rst_rem", {24'd0, rem}, 32'd0);
    check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors; latency is 9 edges counting the accept edge.
    foreach (vecs[k]) begin
      run_op(vecs[k].va, vecs[k].vb, vecs[k].vs, 0, q, r, dz, lat);
      check_eq("dir_quot", {24'd0, q}, {24'd0, vecs[k].eq});
      check_eq("dir_rem", {24'd0, r}, {24'd0, vecs[k].er});
      check_eq("dir_dbz", {31'd0, dz}, {31'd0, vecs[k].ez});
      check_eq("dir_latency", lat, 32'd9);
    end

    // Backpressure: 100/7 with out_ready low for 5 cycles and an in_valid pulse.
    run_op(8'd100, 8'd7, 1'b0, 5, q, r, dz, lat);
    check_eq("bp_quot", {24'd0, q}, 32'd14);
    check_eq("bp_rem", {24'd0, r}, 32'd2);
    check_eq("bp_latency", lat, 32'd9);

    // Asynchronous reset three cycles into CALC, between clock edges.
    @(negedge clk);
    a          = 8'd200;
    b          = 8'd3;
    signed_div = 1'b0;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_quot", {24'd0, quot}, 32'd0);
    check_eq("mid_rst_rem", {24'd0, rem}, 32'd0);
    check_eq("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) bad_valid++;
    end
    check_eq("mid_rst_no_result", bad_valid, 32'd0);
    run_op(8'd100, 8'd10, 1'b0, 0, q, r, dz, lat);
    check_eq("after_rst_quot", {24'd0, q}, 32'd10);
    check_eq("after_rst_rem", {24'd0, r}, 32'd0);
    check_eq("after_rst_dbz", {31'd0, dz}, 32'd0);

    // Random operands, modes, idle gaps and backpressure.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;
      ra = 8'($urandom_range(0, 255));
      rb = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, rs, int'($urandom_range(0, 3)), q, r, dz, lat);
      exp_v = ref_div(ra, rb, rs);
      check_eq("rnd_quot", {24'd0, q}, {24'd0, exp_v[15:8]});
      check_eq("rnd_rem", {24'd0, r}, {24'd0, exp_v[7:0]});
      check_eq("rnd_dbz", {31'd0, dz}, {31'd0, exp_v[16]});
      check_eq("rnd_latency", lat, 32'd9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
